// File: rtl/reloj_disp_pkg.sv
// Shared constants and FSM state type for the clock display sequencer.
package reloj_disp_pkg;

    localparam int         NUM_DIGITS    = 4;
    localparam logic [3:0] BLANK_CODE    = 4'hF;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } disp_state_e;

endpackage

// File: rtl/reloj_scan_prescaler.sv
// Digit-slot prescaler: free-running 0..SCAN_DIV-1 counter, tick on the last count.
module reloj_scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(SCAN_DIV - 1));

    // Count up and wrap to zero on the tick cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/reloj_disp_sequencer.sv
// Four-digit multiplexed display sequencer driving an Avalon-MM output PIO.
// One single-cycle PIO write per digit slot: [7:4] one-hot digit select,
// [3:0] BCD code (or BLANK_CODE when blanked).
// Optional feature: define RELOJ_DISP_BLINK_EN to add blink_mask and a
// frame-counted blink phase that blanks the masked digits.
module reloj_disp_sequencer
    import reloj_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] digit_in,
    input  logic        digit_load,
    input  logic        blank,
`ifdef RELOJ_DISP_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        frame_done
);

    localparam int             IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic             slot_tick;
    disp_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [15:0]      shadow_q;
    logic [15:0]      active_q;
    logic [15:0]      frame_word;
    logic             launch;
    logic             blink_off;
    logic [31:0]      wdata_d;

    reloj_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (slot_tick)
    );

    // Next write's index and data word. The idx 0 slot reads the shadow
    // directly because active takes the shadow on that same edge, so the
    // whole frame comes from one snapshot.
    always_comb begin
        launch     = slot_tick && (state_q != ST_WRITE);
        idx_d      = (state_q == ST_WAIT) ? idx_q + 1'b1 : idx_q;
        frame_word = (idx_d == '0) ? shadow_q : active_q;
        wdata_d    = '0;
        if (blank || blink_off) begin
            wdata_d[3:0] = BLANK_CODE;
        end else begin
            wdata_d[7:4] = 4'b0001 << idx_d;
            wdata_d[3:0] = frame_word[{idx_d, 2'b00} +: 4];
        end
    end

    // Shadow captures every load; active refreshes only at frame start,
    // plus the load that lands in the idx 0 write cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (digit_load) shadow_q <= digit_in;
            if (launch && (idx_d == '0))
                active_q <= shadow_q;
            else if ((state_q == ST_WRITE) && (idx_q == '0) && digit_load)
                active_q <= digit_in;
        end
    end

    // Scan FSM with registered Avalon write outputs and frame_done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= PIO_DATA_ADDR;
            pio_writedata  <= '0;
            frame_done     <= 1'b0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= PIO_DATA_ADDR;
            pio_writedata  <= '0;
            frame_done     <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (launch) begin
                        state_q        <= ST_WRITE;
                        idx_q          <= idx_d;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= wdata_d;
                    end
                end
                ST_WRITE: begin
                    state_q    <= ST_WAIT;
                    frame_done <= (idx_q == LAST_IDX);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef RELOJ_DISP_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] frame_cnt_q;
    logic           blink_phase_q;

    assign blink_off = blink_phase_q & blink_mask[idx_d];

    // Count finished frames; flip the phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if ((state_q == ST_WRITE) && (idx_q == LAST_IDX)) begin
            if (frame_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end
`else
    assign blink_off = 1'b0;
`endif

endmodule

// File: tb/tb_reloj_disp_sequencer.sv
// Self-checking bench for reloj_disp_sequencer (SCAN_DIV=4, BLINK_FRAMES=2).
// Reference model works from write timing arithmetic: write k lands SCAN_DIV*(k+1)
// cycles after reset release, digit index k mod 4.
module tb_reloj_disp_sequencer;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digit_in = 16'h0;
    logic        digit_load = 1'b0;
    logic        blank = 1'b0;
`ifdef RELOJ_DISP_BLINK_EN
    logic [3:0]  blink_mask = 4'h0;
`endif
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        frame_done;

    reloj_disp_sequencer #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .digit_in       (digit_in),
        .digit_load     (digit_load),
        .blank          (blank),
`ifdef RELOJ_DISP_BLINK_EN
        .blink_mask     (blink_mask),
`endif
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          c = 0;
    int          m_frames = 0;
    int          w_idx = -1;
    logic [15:0] m_sh = 16'h0;
    logic [15:0] m_act = 16'h0;
    logic [3:0]  m_mask = 4'h0;
    logic        e_cs = 1'b0;
    logic        e_fd = 1'b0;
    logic [31:0] e_wd = 32'h0;

    function automatic logic [36:0] got_vec();
        return {pio_chipselect, pio_write_n, pio_address, pio_writedata, frame_done};
    endfunction

    function automatic logic [36:0] exp_vec();
        return {e_cs, ~e_cs, 2'b00, e_wd, e_fd};
    endfunction

    // Expected outputs after edge number c, given the inputs sampled at that edge.
    task automatic model_edge(input logic ld, input logic [15:0] din, input logic blk);
        int idx;
        int pidx;
        bit launch;
        bit prevw;
        bit blinked;
        c++;
        prevw = ((c - 1) % SD == 0) && (c - 1 >= SD);
        pidx  = ((c - 1) / SD - 1) % 4;
        e_fd  = prevw && (pidx == 3);
        if (e_fd) m_frames++;
        launch = (c % SD == 0);
        idx    = (c / SD - 1) % 4;
        if (prevw && pidx == 0 && ld) m_act = din;
        if (launch && idx == 0) m_act = m_sh;
        e_cs  = launch;
        e_wd  = 32'h0;
        w_idx = -1;
        if (launch) begin
            w_idx   = idx;
            blinked = ((m_frames / BF) % 2 == 1) && m_mask[idx];
            if (blk || blinked) e_wd = 32'h0000_000F;
            else                e_wd = {24'h0, 4'(1 << idx), m_act[idx*4 +: 4]};
        end
        if (ld) m_sh = din;
    endtask

    task automatic step(input logic ld, input logic [15:0] din, input logic blk);
        digit_load = ld;
        digit_in   = din;
        blank      = blk;
        @(posedge clk);
        model_edge(ld, din, blk);
        #1;
        digit_load = 1'b0;
    endtask

    task automatic model_clear();
        c = 0; m_sh = 16'h0; m_act = 16'h0; m_frames = 0;
        e_cs = 1'b0; e_wd = 32'h0; e_fd = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; digit_load = 1'b0; blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_vec() !== 37'h1_0000_0000_0 << 1 >> 1 && got_vec() !== {1'b0, 1'b1, 2'b00, 32'h0, 1'b0})
            ;
        if (got_vec() !== {1'b0, 1'b1, 2'b00, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", got_vec(), {1'b0, 1'b1, 2'b00, 32'h0, 1'b0});
        end
        do_reset();
        for (int i = 1; i <= SD; i++) begin
            step(1'b0, 16'h0, 1'b0);
            checks++;
            if (pio_chipselect !== (i == SD)) begin
                errors++;
                $display("FAIL first_write_latency c=%0d: cs got %b want %b", i, pio_chipselect, i == SD);
            end
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
        end
        checks++;
        if (pio_writedata !== 32'h10) begin
            errors++;
            $display("FAIL first_write_data: got %h want %h", pio_writedata, 32'h10);
        end
    endtask

    task automatic test_scan_pattern();
        logic [7:0] tbl [8];
        int n;
        tbl = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h14, 8'h23, 8'h42, 8'h81};
        n = 0;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(i == 6, 16'h1234, 1'b0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL scan_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
            if (pio_chipselect && n < 8) begin
                checks++;
                if (pio_writedata !== {24'h0, tbl[n]}) begin
                    errors++;
                    $display("FAIL scan_table write%0d: got %h want %h", n, pio_writedata, tbl[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL scan_write_count: got %0d want 8", n);
        end
    endtask

    task automatic test_blank();
        int ncs;
        ncs = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 16'h1234, 1'b1);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL blank_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
            if (pio_chipselect) begin
                ncs++;
                checks++;
                if (pio_writedata !== 32'h0F) begin
                    errors++;
                    $display("FAIL blank_code: got %h want %h", pio_writedata, 32'h0F);
                end
            end
        end
        checks++;
        if (ncs != 4) begin
            errors++;
            $display("FAIL blank_cadence: got %0d writes want 4", ncs);
        end
    endtask

    task automatic test_midframe_load();
        logic [7:0] tbl [6];
        tbl = '{8'h42, 8'h81, 8'h18, 8'h27, 8'h46, 8'h85};
        do_reset();
        for (int i = 1; i <= 48; i++) begin
            step(i == 6 || i == 30, (i == 30) ? 16'h5678 : 16'h1234, 1'b0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midload_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
            if (i >= 28 && i % SD == 0) begin
                checks++;
                if (pio_chipselect !== 1'b1 || pio_writedata !== {24'h0, tbl[(i - 28) / SD]}) begin
                    errors++;
                    $display("FAIL midload_table c=%0d: got cs=%b %h want %h", i, pio_chipselect,
                             pio_writedata, tbl[(i - 28) / SD]);
                end
            end
        end
    endtask

    task automatic test_hex_passthrough();
        logic [3:0] nib [4];
        int pulses;
        int last_fd;
        nib = '{4'hC, 4'hD, 4'hE, 4'hF};
        pulses = 0;
        last_fd = 0;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(i == 2, 16'hFEDC, 1'b0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hex_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
            if (pio_chipselect && w_idx >= 0) begin
                checks++;
                if (pio_writedata[3:0] !== nib[w_idx]) begin
                    errors++;
                    $display("FAIL hex_nibble idx%0d: got %h want %h", w_idx, pio_writedata[3:0], nib[w_idx]);
                end
            end
            if (frame_done) begin
                if (pulses > 0) begin
                    checks++;
                    if (i - last_fd != 16) begin
                        errors++;
                        $display("FAIL frame_done_period: got %0d want 16", i - last_fd);
                    end
                end
                pulses++;
                last_fd = i;
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL frame_done_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        k = 0;
        while (pio_chipselect !== 1'b1 && k < 3 * SD) begin
            step(1'b0, digit_in, 1'b0);
            k++;
        end
        checks++;
        if (pio_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL wait_write_timeout: cs got %b want 1", pio_chipselect);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_drop: got cs=%b wn=%b want cs=0 wn=1", pio_chipselect, pio_write_n);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        for (int i = 1; i <= SD; i++) begin
            step(1'b0, 16'h9999, 1'b0);
            checks++;
            if (got_vec() !== exp_vec() || pio_chipselect !== (i == SD)) begin
                errors++;
                $display("FAIL rewrite_after_reset c=%0d: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (pio_writedata[7:4] !== 4'h1) begin
            errors++;
            $display("FAIL rewrite_idx0: got %h want 1", pio_writedata[7:4]);
        end
    endtask

    task automatic test_random();
        logic ld;
        logic blk;
        do_reset();
        blk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(7) == 0);
            if (i % 40 == 0) blk = ($urandom_range(3) == 0);
            step(ld, 16'($urandom), blk);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
        end
    endtask

`ifdef RELOJ_DISP_BLINK_EN
    task automatic test_blink();
        int f;
        do_reset();
        m_mask = 4'b0001;
        blink_mask = m_mask;
        for (int i = 1; i <= 100; i++) begin
            step(i == 6, 16'h1234, 1'b0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL blink_model c=%0d: got %h want %h", c, got_vec(), exp_vec());
            end
            if (i % SD == 0 && ((i / SD - 1) % 4) == 0) begin
                f = (i / SD - 1) / 4 + 1;
                if (f >= 3 && f <= 6) begin
                    checks++;
                    if (pio_writedata !== ((f <= 4) ? 32'h0F : 32'h14)) begin
                        errors++;
                        $display("FAIL blink_frame%0d: got %h want %h", f, pio_writedata,
                                 (f <= 4) ? 32'h0F : 32'h14);
                    end
                end
            end
        end
        m_mask = 4'h0;
        blink_mask = 4'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan_pattern();
        test_blank();
        test_midframe_load();
        test_hex_passthrough();
        test_reset_mid_write();
        test_random();
`ifdef RELOJ_DISP_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
